aes_vector_player: RTL and testbench
====================================

Name: aes_vector_player

Overview:
Synthesisable, parametrised stimulus/response engine that replays a table of plaintext/key vectors into the AES_top core and checks each result against an expected ciphertext. It generalises the fixed single-shot sequence used to exercise the core: programmable table depth, vector count, inter-vector gap, a response timeout and pass/fail accounting. It sits between a configuration host (or bench) and the AES_top core port set.

Parameters:
DATA_W, 128, plaintext/ciphertext width
KEY_W, 128, key width
DEPTH, 8, table entries (power of 2, >=2)
GAP_W, 8, width of inter-vector gap count
TIMEOUT, 64, max cycles from issue to AES_data_out_valid before the vector is scored a fail
IW = $clog2(DEPTH), CW = $clog2(DEPTH+1) (derived, localparam)

Ports:
AES_clk  in  1  clock, rising edge
AES_rst_n  in  1  asynchronous active-low reset
wr_en  in  1  table write strobe
wr_addr  in  IW  table index
wr_data  in  DATA_W  plaintext for entry
wr_key  in  KEY_W  key for entry
wr_expect  in  DATA_W  expected ciphertext for entry
start  in  1  begin run (level-sampled, acted on in IDLE only)
abort  in  1  abandon run
num_vec  in  CW  vectors to play (sampled at start)
gap  in  GAP_W  idle cycles between vectors (sampled at start)
AES_en  out  1  core enable
AES_data_in  out  DATA_W  core plaintext
AES_key_in  out  KEY_W  core key
AES_data_out  in  DATA_W  core result
AES_data_out_valid  in  1  core result strobe (one-cycle pulse)
busy  out  1  run in progress
done  out  1  one-cycle end-of-run pulse
pass_cnt  out  CW  matching results
fail_cnt  out  CW  mismatches plus timeouts
timeout_err  out  1  sticky: at least one timeout this run
first_fail_idx  out  IW  index of first failing vector (valid when fail_cnt>0)

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM=IDLE, table contents undefined (not reset).
- Table writes accepted only in IDLE; wr_en while busy ignored.
- FSM: IDLE, ISSUE, WAIT, GAP, FIN.
- IDLE: start=1 -> clear pass_cnt/fail_cnt/timeout_err/first_fail_idx, latch n=min(num_vec,DEPTH), latch gap, idx=0; n=0 -> FIN, else ISSUE. busy=1 from the cycle after start.
- ISSUE (1 cycle): register AES_data_in/AES_key_in from table[idx], AES_en=1 from next cycle; -> WAIT, timer=0.
- WAIT: AES_en held 1, data/key held stable. AES_data_out_valid=1 -> compare AES_data_out with expect[idx]: equal -> pass_cnt+1, else fail_cnt+1 (record idx if first fail). timer reaches TIMEOUT-1 without valid -> fail_cnt+1, timeout_err=1, record idx if first fail. Either case: AES_en=0 next cycle, -> GAP.
- GAP: hold AES_en=0 for `gap` cycles (gap=0: zero cycles); then idx+1 -> ISSUE, or after last vector -> FIN.
- FIN: done=1 for exactly one cycle, busy=0 same cycle, -> IDLE. Counters and status held until next start.
- AES_data_out_valid outside WAIT ignored (no count change).
- Valid and timeout in same cycle: valid wins (scored by compare).
- abort (any non-IDLE state): next cycle AES_en=0, -> IDLE, busy=0, no done pulse, counters frozen.
- start while busy ignored. Reset mid-run: immediate return to reset values.
- pass_cnt+fail_cnt never exceeds n; no wrap.

Test Plan:
- Entry0 key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, expect 69c4e0d86a7b0430d8cdb78070b4c55a; num_vec=1, gap=0 -> AES_en high ISSUE+1 until valid, done pulse, pass_cnt=1, fail_cnt=0.
- 4 entries, entry2 expect corrupted (LSB flipped), gap=3 -> pass_cnt=3, fail_cnt=1, first_fail_idx=2, exactly 3 low AES_en cycles between vectors.
- Core model never asserts valid, TIMEOUT=64 -> AES_en drops after 64 WAIT cycles, fail_cnt=1, timeout_err=1, done pulses.
- num_vec=0 -> done pulse 1 cycle after start, counters 0, AES_en never high; num_vec=DEPTH+1 -> exactly DEPTH vectors issued.
- abort during WAIT of vector 1 of 4 -> AES_en low next cycle, busy=0, no done, pass_cnt=1; wr_en during run leaves table unchanged.
- AES_rst_n low mid-WAIT -> all outputs 0 asynchronously; valid pulse injected in GAP -> counters unchanged.

Source files
------------

// File: rtl/aes_vector_player.sv
// aes_vector_player: replays a plaintext/key/expect table into an AES core and scores the results
module aes_vector_player #(
  parameter int DATA_W  = 128,
  parameter int KEY_W   = 128,
  parameter int DEPTH   = 8,
  parameter int GAP_W   = 8,
  parameter int TIMEOUT = 64,
  localparam int IW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              AES_clk,
  input  logic              AES_rst_n,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [DATA_W-1:0] wr_expect,
  input  logic              start,
  input  logic              abort,
  input  logic [CW-1:0]     num_vec,
  input  logic [GAP_W-1:0]  gap,
  output logic              AES_en,
  output logic [DATA_W-1:0] AES_data_in,
  output logic [KEY_W-1:0]  AES_key_in,
  input  logic [DATA_W-1:0] AES_data_out,
  input  logic              AES_data_out_valid,
  output logic              busy,
  output logic              done,
  output logic [CW-1:0]     pass_cnt,
  output logic [CW-1:0]     fail_cnt,
  output logic              timeout_err,
  output logic [IW-1:0]     first_fail_idx
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, FIN} state_t;
  state_t state;
  logic [DATA_W-1:0] tbl_d [DEPTH];
  logic [KEY_W-1:0]  tbl_k [DEPTH];
  logic [DATA_W-1:0] tbl_e [DEPTH];
  logic [CW-1:0]     n, n_in;
  logic [GAP_W-1:0]  gap_r, gcnt;
  logic [IW-1:0]     idx, nxt;
  logic [TW-1:0]     timer;
  logic              last, hit, match, tmo, fail;
  assign n_in  = (num_vec > CW'(DEPTH)) ? CW'(DEPTH) : num_vec;
  assign nxt   = idx + 1'b1;
  assign last  = (CW'(idx) + CW'(1)) == n;
  assign hit   = AES_data_out_valid;
  assign match = AES_data_out == tbl_e[idx];
  assign tmo   = !hit && (timer == TW'(TIMEOUT - 1));
  assign fail  = (hit && !match) || tmo;
  // Vector table: writable only while idle, deliberately left unreset
  always_ff @(posedge AES_clk) begin
    if (wr_en && state == IDLE) begin
      tbl_d[wr_addr] <= wr_data;
      tbl_k[wr_addr] <= wr_key;
      tbl_e[wr_addr] <= wr_expect;
    end
  end
  // Run sequencer: issue each vector, wait for result or timeout, score it, then idle for the gap
  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state          <= IDLE;
      AES_en         <= 1'b0;
      AES_data_in    <= '0;
      AES_key_in     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      timeout_err    <= 1'b0;
      first_fail_idx <= '0;
      n              <= '0;
      gap_r          <= '0;
      gcnt           <= '0;
      idx            <= '0;
      timer          <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state  <= IDLE;
        AES_en <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            timeout_err    <= 1'b0;
            first_fail_idx <= '0;
            n              <= n_in;
            gap_r          <= gap;
            idx            <= '0;
            busy           <= n_in != '0;
            done           <= n_in == '0;
            state          <= (n_in == '0) ? FIN : ISSUE;
          end
          ISSUE: begin
            AES_data_in <= tbl_d[idx];
            AES_key_in  <= tbl_k[idx];
            AES_en      <= 1'b1;
            timer       <= '0;
            state       <= WAIT;
          end
          WAIT: if (hit || tmo) begin
            pass_cnt    <= pass_cnt + CW'(hit && match);
            fail_cnt    <= fail_cnt + CW'(fail);
            timeout_err <= timeout_err | tmo;
            if (fail && fail_cnt == '0) first_fail_idx <= idx;
            AES_en <= 1'b0;
            gcnt   <= gap_r - 1'b1;
            if (gap_r != '0) state <= GAP;
            else if (last) begin
              state <= FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              idx   <= nxt;
              state <= ISSUE;
            end
          end else timer <= timer + 1'b1;
          // The final gap cycle doubles as the issue of the next vector so the gap is exact
          GAP: if (gcnt != '0) gcnt <= gcnt - 1'b1;
          else if (last) begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            idx         <= nxt;
            AES_data_in <= tbl_d[nxt];
            AES_key_in  <= tbl_k[nxt];
            AES_en      <= 1'b1;
            timer       <= '0;
            state       <= WAIT;
          end
          FIN: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_aes_vector_player.sv
// tb_aes_vector_player: scoreboard bench driving directed vectors through a behavioural core model
module tb_aes_vector_player;
  localparam int DEPTH = 8;
  localparam int IW = 3;
  localparam int CW = 4;
  localparam logic [127:0] F_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] F_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] F_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic AES_clk = 0, AES_rst_n = 0, wr_en = 0, start = 0, abort = 0;
  logic cv = 0, inj = 0, core_on = 1;
  logic [IW-1:0] wr_addr = '0;
  logic [127:0] wr_data = '0, wr_key = '0, wr_expect = '0, cdout = '0;
  logic [CW-1:0] num_vec = '0;
  logic [7:0] gap = '0;
  logic AES_en, busy, done, timeout_err;
  logic [127:0] AES_data_in, AES_key_in;
  logic [CW-1:0] pass_cnt, fail_cnt;
  logic [IW-1:0] first_fail_idx;
  int lat = 2, errors = 0, checks = 0;
  logic [127:0] tpt [DEPTH];
  logic [127:0] tkey [DEPTH];
  logic [127:0] texp [DEPTH];

  typedef struct {int p; int f; int t; int i;} exp_t;
  exp_t sb[$];

  always #5 AES_clk = ~AES_clk;

  aes_vector_player dut (
    .AES_clk(AES_clk), .AES_rst_n(AES_rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_key(wr_key), .wr_expect(wr_expect), .start(start),
    .abort(abort), .num_vec(num_vec), .gap(gap), .AES_en(AES_en),
    .AES_data_in(AES_data_in), .AES_key_in(AES_key_in), .AES_data_out(cdout),
    .AES_data_out_valid(cv | inj), .busy(busy), .done(done), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .timeout_err(timeout_err), .first_fail_idx(first_fail_idx)
  );

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endfunction

  // Core model: answers lat+1 cycles after enable with the FIPS-197 result or pt^key
  int ecnt = 0;
  bit fired = 0;
  always @(negedge AES_clk) begin
    cv = 0;
    if (!AES_en) begin
      ecnt = 0;
      fired = 0;
    end else if (core_on && !fired) begin
      if (ecnt == lat) begin
        cv = 1;
        cdout = (AES_data_in == F_PT && AES_key_in == F_KEY) ? F_CT : AES_data_in ^ AES_key_in;
        fired = 1;
      end
      ecnt++;
    end
  end

  // Enable activity monitor: high cycles, issue count, low runs between vectors of a run
  int hi_total = 0, issues = 0, lowrun = 0;
  bit seen_hi = 0;
  logic en_d = 0;
  int lows[$];
  always @(negedge AES_clk) begin
    if (AES_en) begin
      hi_total++;
      if (!en_d) begin
        issues++;
        if (seen_hi) lows.push_back(lowrun);
      end
      seen_hi = 1;
      lowrun = 0;
    end else if (seen_hi) lowrun++;
    if (!busy) begin
      seen_hi = 0;
      lowrun = 0;
    end
    en_d = AES_en;
  end

  // Scoreboard: every done pulse is matched against the oldest expected run result
  always @(negedge AES_clk) begin : mon
    exp_t e;
    if (AES_rst_n && done) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("pass_cnt", pass_cnt, e.p);
        chk("fail_cnt", fail_cnt, e.f);
        chk("timeout_err", timeout_err, e.t);
        chk("busy_at_done", busy, 0);
        if (e.f > 0) chk("first_fail_idx", first_fail_idx, e.i);
      end
    end
  end

  task automatic write_entry(int a, logic [127:0] d, logic [127:0] k, logic [127:0] e);
    wr_en = 1; wr_addr = IW'(a); wr_data = d; wr_key = k; wr_expect = e;
    @(negedge AES_clk);
    wr_en = 0;
  endtask

  task automatic start_run(int nv, int g, int p, int f, int t, int i, bit push);
    if (push) sb.push_back('{p, f, t, i});
    num_vec = CW'(nv); gap = 8'(g); start = 1;
    @(negedge AES_clk);
    start = 0;
  endtask

  task automatic wait_done(output int k);
    for (k = 0; k < 2000; k++) begin
      if (done) break;
      @(negedge AES_clk);
    end
    if (k == 2000) chk("done_timeout", 0, 1);
    @(negedge AES_clk);
  endtask

  initial begin
    int k, b_hi, b_is;
    for (int i = 0; i < DEPTH; i++) begin
      tpt[i]  = (i == 0) ? F_PT : {4{32'(i) * 32'h01010101}};
      tkey[i] = (i == 0) ? F_KEY : {4{32'hA5A5A5A5 ^ 32'(i)}};
      texp[i] = (i == 0) ? F_CT : tpt[i] ^ tkey[i];
    end
    repeat (2) @(negedge AES_clk);
    chk("rst_en", AES_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", AES_data_in, 0);
    chk("rst_pass", pass_cnt, 0);
    AES_rst_n = 1;
    @(negedge AES_clk);
    for (int i = 0; i < DEPTH; i++) write_entry(i, tpt[i], tkey[i], (i == 2) ? texp[i] ^ 128'h1 : texp[i]);
    b_hi = hi_total;
    start_run(1, 0, 1, 0, 0, 0, 1);
    wait_done(k);
    chk("t1_en_high", hi_total - b_hi, lat + 1);
    lows.delete();
    start_run(4, 3, 3, 1, 0, 2, 1);
    wait_done(k);
    chk("t2_gap_count", lows.size(), 3);
    foreach (lows[j]) chk("t2_gap_len", lows[j], 3);
    core_on = 0;
    b_hi = hi_total;
    start_run(1, 0, 0, 1, 1, 0, 1);
    wait_done(k);
    chk("t3_en_high", hi_total - b_hi, 64);
    core_on = 1;
    b_hi = hi_total;
    start_run(0, 0, 0, 0, 0, 0, 1);
    wait_done(k);
    chk("t4_done_lat", k, 0);
    chk("t4_en_high", hi_total - b_hi, 0);
    write_entry(2, tpt[2], tkey[2], texp[2]);
    b_is = issues;
    start_run(DEPTH + 1, 0, DEPTH, 0, 0, 0, 1);
    wait_done(k);
    chk("t5_issues", issues - b_is, DEPTH);
    b_is = issues;
    start_run(4, 1, 0, 0, 0, 0, 0);
    write_entry(0, ~tpt[0], tkey[0], texp[0]);
    for (k = 0; k < 500 && issues - b_is < 2; k++) @(negedge AES_clk);
    chk("t6_reach_vec1", issues - b_is, 2);
    abort = 1;
    @(negedge AES_clk);
    abort = 0;
    chk("t6_abort_en", AES_en, 0);
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_pass", pass_cnt, 1);
    repeat (20) @(negedge AES_clk);
    chk("t6_pass_frozen", pass_cnt, 1);
    start_run(1, 0, 1, 0, 0, 0, 1);
    wait_done(k);
    lat = 1;
    b_is = issues;
    start_run(2, 5, 2, 0, 0, 0, 1);
    for (k = 0; k < 200 && (issues - b_is < 1 || AES_en); k++) @(negedge AES_clk);
    inj = 1;
    @(negedge AES_clk);
    inj = 0;
    chk("t7_gap_valid_ignored", pass_cnt, 1);
    wait_done(k);
    core_on = 0;
    start_run(1, 0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge AES_clk);
    chk("t8_en_before", AES_en, 1);
    chk("t8_busy_before", busy, 1);
    #2 AES_rst_n = 0;
    #1;
    chk("t8_rst_en", AES_en, 0);
    chk("t8_rst_busy", busy, 0);
    chk("t8_rst_data", AES_data_in, 0);
    chk("t8_rst_key", AES_key_in, 0);
    chk("t8_rst_fail", fail_cnt, 0);
    @(negedge AES_clk);
    AES_rst_n = 1;
    core_on = 1;
    repeat (3) @(negedge AES_clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
